// File: rtl/uart_ascii_pkg.sv
// Shared constants, FSM state type and ASCII hex decode helper for the UART hex receiver.
// Latency: n/a (declarations and a pure combinational function).
// Backpressure: n/a.
package uart_ascii_pkg;

  // Control characters
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Hex digit ranges: '0'-'9', 'A'-'F', 'a'-'f'
  localparam logic [7:0] DIGIT_LO = 8'h30;
  localparam logic [7:0] DIGIT_HI = 8'h39;
  localparam logic [7:0] UPPER_LO = 8'h41;
  localparam logic [7:0] UPPER_HI = 8'h46;
  localparam logic [7:0] LOWER_LO = 8'h61;
  localparam logic [7:0] LOWER_HI = 8'h66;

  // Bit-level receive FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Returns {is_hex, nibble}; nibble is 0 when the byte is not a hex digit.
  // Letters map via the low nibble + 9, which covers both cases at once.
  function automatic logic [4:0] hex_nibble(input logic [7:0] b);
    logic [4:0] r;
    r = 5'b0;
    if (b >= DIGIT_LO && b <= DIGIT_HI) begin
      r = {1'b1, 4'(b - DIGIT_LO)};
    end else if ((b >= UPPER_LO && b <= UPPER_HI) ||
                 (b >= LOWER_LO && b <= LOWER_HI)) begin
      r = {1'b1, 4'(b[3:0] + 4'd9)};
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, idle qualification and bit-timing FSM.
// Latency: byte_done/frame_err_raw assert combinationally in the stop-bit sample cycle.
// Backpressure: none; every received byte is presented once and must be consumed that cycle.
module uart_rx_byte
  import uart_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       frame_err_raw
);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1;
  logic             rxs;
  logic [1:0]       sync_fill;
  logic             seen_idle;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             stop_sample;

  // Two-flop synchronizer; sync_fill tracks when rxs holds a real sample
  // rather than the reset preload, so a line held low through reset release
  // cannot be mistaken for idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      rxs       <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      sync1     <= rx;
      rxs       <= sync1;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Arm start-bit detection only once the line has genuinely been seen high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_idle <= 1'b0;
    end else if (sync_fill[1] && rxs) begin
      seen_idle <= 1'b1;
    end
  end

  // Bit-timing FSM: mid-start check, then one sample per bit period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (seen_idle && !rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            // Line back high at mid-start means a glitch, not a frame.
            state   <= rxs ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt            <= '0;
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            // Return at mid-stop so an immediate next start edge is caught.
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The stop-bit sample cycle qualifies the assembled byte.
  assign stop_sample   = (state == STOP) && (cnt == FULL_M1);
  assign byte_done     = stop_sample && rxs;
  assign frame_err_raw = stop_sample && !rxs;
  assign rx_byte       = shreg;

endmodule

// File: rtl/uart_ascii_hex_rx.sv
// ASCII hex line receiver: accumulates up to four hex digits and commits them on CR.
// Latency: data/data_valid/char_err/frame_err/nibble_cnt update 1 clk after the stop-bit sample.
// Backpressure: none; data_valid is a single-cycle strobe and data holds until the next commit.
module uart_ascii_hex_rx
  import uart_ascii_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [15:0] data,
  output logic        data_valid,
  output logic        char_err,
  output logic        frame_err,
  output logic [2:0]  nibble_cnt
);

  logic [7:0]  rx_byte;
  logic        byte_done;
  logic        frame_err_raw;
  logic [4:0]  hex_info;
  logic [15:0] acc;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_rx_byte (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx            (rx),
    .rx_byte       (rx_byte),
    .byte_done     (byte_done),
    .frame_err_raw (frame_err_raw)
  );

  assign hex_info = hex_nibble(rx_byte);

  // Decode each received byte: shift in digits, commit on CR, clear on errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data       <= 16'h0000;
      data_valid <= 1'b0;
      char_err   <= 1'b0;
      frame_err  <= 1'b0;
      nibble_cnt <= 3'd0;
      acc        <= 16'h0000;
    end else begin
      data_valid <= 1'b0;
      char_err   <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_err_raw) begin
        // Corrupt frame: drop the byte and any partial value.
        frame_err  <= 1'b1;
        acc        <= 16'h0000;
        nibble_cnt <= 3'd0;
      end else if (byte_done) begin
        if (hex_info[4]) begin
          // Oldest digit falls off the top, so the last four are kept.
          acc <= {acc[11:0], hex_info[3:0]};
          if (nibble_cnt != 3'd4) begin
            nibble_cnt <= nibble_cnt + 3'd1;
          end
        end else if (rx_byte == ASCII_CR) begin
          // A bare CR (no digits) is a no-op rather than committing zero.
          if (nibble_cnt != 3'd0) begin
            data       <= acc;
            data_valid <= 1'b1;
            acc        <= 16'h0000;
            nibble_cnt <= 3'd0;
          end
        end else if (rx_byte != ASCII_LF) begin
          // Anything other than a digit, CR or LF poisons the current value.
          char_err   <= 1'b1;
          acc        <= 16'h0000;
          nibble_cnt <= 3'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_ascii_hex_rx.sv
module tb_uart_ascii_hex_rx;

  localparam int CPB   = 16;
  localparam int CNT_W = 5;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic [15:0] data;
  logic        data_valid;
  logic        char_err;
  logic        frame_err;
  logic [2:0]  nibble_cnt;

  uart_ascii_hex_rx #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .char_err   (char_err),
    .frame_err  (frame_err),
    .nibble_cnt (nibble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output events: 0 = data_valid, 1 = char_err, 2 = frame_err
  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fails  = 0;

  // Reference model state: a value built from digits with plain arithmetic
  int m_acc  = 0;
  int m_cnt  = 0;
  int m_data = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int hex_val(input int b);
    if (b >= "0" && b <= "9") return b - 48;
    if (b >= "A" && b <= "F") return b - 55;
    if (b >= "a" && b <= "f") return b - 87;
    return -1;
  endfunction

  task automatic model_byte(input int b, input bit stop_ok);
    ev_t e;
    int  v;
    v = hex_val(b);
    if (!stop_ok) begin
      e.kind = 2; e.val = 16'h0;
      exp_q.push_back(e);
      m_acc = 0; m_cnt = 0;
    end else if (v >= 0) begin
      m_acc = (m_acc * 16 + v) % 65536;
      m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
    end else if (b == 13) begin
      if (m_cnt > 0) begin
        m_data = m_acc;
        e.kind = 0; e.val = 16'(m_data);
        exp_q.push_back(e);
        m_acc = 0; m_cnt = 0;
      end
    end else if (b != 10) begin
      e.kind = 1; e.val = 16'h0;
      exp_q.push_back(e);
      m_acc = 0; m_cnt = 0;
    end
  endtask

  task automatic bit_time(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Sends one frame (called at a negedge); checks settled state afterwards.
  task automatic send_byte(input int b, input bit stop_ok = 1'b1);
    logic [7:0] bb;
    bb = 8'(b);
    model_byte(b, stop_ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(bb[i]);
    bit_time(stop_ok);
    rx = 1'b1;
    chk("nibble_cnt_after_byte", int'(nibble_cnt), m_cnt);
    chk("data_after_byte", int'(data), m_data);
    if (!stop_ok) repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(int'(s[i]));
  endtask

  // Monitor: every strobe must match the next expected event.
  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (data_valid === 1'b1 || char_err === 1'b1 || frame_err === 1'b1) begin
      chk("strobes_onehot", int'(data_valid) + int'(char_err) + int'(frame_err), 1);
      k = data_valid ? 0 : (char_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe_kind", k, -1);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_kind", k, e.kind);
        if (k == 0) chk("committed_data", int'(data), int'(e.val));
      end
    end
  end

  // Watchdog
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
    $fatal(1);
  end

  initial begin
    string hexchars;
    int    r;
    int    b;
    logic [7:0] five;
    hexchars = "0123456789ABCDEFabcdef";
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_data", int'(data), 0);
    chk("reset_data_valid", int'(data_valid), 0);
    chk("reset_char_err", int'(char_err), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_nibble_cnt", int'(nibble_cnt), 0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Directed cases
    send_str("12AF"); send_byte(13);
    send_str("b3");   send_byte(13);
    send_byte(10);    send_byte(13);
    send_str("12345"); send_byte(13);
    send_str("1G2");  send_byte(13);
    send_byte("7", 1'b0); send_byte(13);
    send_byte("9");   send_byte(13);

    // Short low glitch must not produce a byte
    rx = 1'b0; repeat (4) @(negedge clk);
    rx = 1'b1; repeat (2 * CPB) @(negedge clk);
    chk("glitch_nibble_cnt", int'(nibble_cnt), 0);

    // Reset in the middle of the data bits of '5'
    send_byte("1");
    five = 8'h35;
    bit_time(1'b0);
    for (int i = 0; i < 3; i++) bit_time(five[i]);
    rx = five[3];
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b0;
    @(negedge clk);
    chk("midreset_data", int'(data), 0);
    chk("midreset_data_valid", int'(data_valid), 0);
    chk("midreset_char_err", int'(char_err), 0);
    chk("midreset_frame_err", int'(frame_err), 0);
    chk("midreset_nibble_cnt", int'(nibble_cnt), 0);
    m_acc = 0; m_cnt = 0; m_data = 0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("post_reset_nibble_cnt", int'(nibble_cnt), 0);
    send_byte("3"); send_byte(13);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        b = int'(hexchars[$urandom_range(0, 21)]);
        send_byte(b);
      end else if (r < 75) begin
        send_byte(13);
      end else if (r < 82) begin
        send_byte(10);
      end else if (r < 92) begin
        do b = $urandom_range(0, 255); while (hex_val(b) >= 0 || b == 13 || b == 10);
        send_byte(b);
      end else begin
        send_byte($urandom_range(0, 255), 1'b0);
      end
      if ($urandom_range(0, 3) != 0) repeat ($urandom_range(1, 40)) @(negedge clk);
    end

    repeat (4 * CPB) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
